// File: rtl/store_lane_packer_pkg.sv
// Shared encodings for the store lane packer: access sizes, FSM states,
// lane count and the aligned lane-replication helper.
// Optional feature macro: STORE_LANE_SPLIT_EN (adds the SECOND state).
package store_lane_packer_pkg;

  localparam int LANES = 4;

  // Same encoding as the load/immediate extender ops.
  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

`ifdef STORE_LANE_SPLIT_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FULL   = 2'd1,
    ST_SECOND = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FULL = 2'd1
  } state_e;
`endif

  // Replicate the narrow value across the word so any enabled lane sees it.
  function automatic logic [31:0] lane_repl(input size_e size, input logic [31:0] data);
    case (size)
      SZ_BYTE: lane_repl = {4{data[7:0]}};
      SZ_HALF: lane_repl = {2{data[15:0]}};
      default: lane_repl = data;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_packer_lane_gen.sv
// store_lane_gen: maps (byte offset, size, data) to lane enables and placed write data.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Ports: off/size/data in; be/wdata/misaligned out; be2/wdata2/needs_second with STORE_LANE_SPLIT_EN.
module store_lane_gen
  import store_lane_packer_pkg::*;
(
  input  logic [1:0]       off,
  input  size_e            size,
  input  logic [31:0]      data,
  output logic [LANES-1:0] be,
  output logic [31:0]      wdata,
`ifdef STORE_LANE_SPLIT_EN
  output logic [LANES-1:0] be2,
  output logic [31:0]      wdata2,
  output logic             needs_second,
`endif
  output logic             misaligned
);

  logic [3:0] mask;
  logic [7:0] span;  // enables over two consecutive words

  always_comb begin
    case (size)
      SZ_WORD: mask = 4'b1111;
      SZ_HALF: mask = 4'b0011;
      SZ_BYTE: mask = 4'b0001;
      default: mask = 4'b0000;
    endcase
    span = {4'b0000, mask} << off;
  end

`ifdef STORE_LANE_SPLIT_EN
  logic [5:0] shamt2;

  always_comb begin
    be           = '0;
    wdata        = '0;
    be2          = '0;
    wdata2       = '0;
    shamt2       = 6'd32 - {1'b0, off, 3'b000};
    misaligned   = (size == SZ_RSVD);
    if (!misaligned) begin
      be  = span[3:0];
      be2 = span[7:4];
      // Naturally aligned cases keep the replicated form; the rest shift.
      if (off == 2'd0 || size == SZ_BYTE || (size == SZ_HALF && off == 2'd2)) begin
        wdata = lane_repl(size, data);
      end else begin
        wdata  = data << {off, 3'b000};
        wdata2 = data >> shamt2;
      end
    end
    needs_second = |be2;
  end
`else
  always_comb begin
    be         = '0;
    wdata      = '0;
    misaligned = (size == SZ_RSVD) ||
                 (size == SZ_HALF && off[0]) ||
                 (size == SZ_WORD && off != 2'd0);
    if (!misaligned) begin
      be    = span[3:0];
      wdata = lane_repl(size, data);
    end
  end
`endif

endmodule

// File: rtl/store_lane_packer.sv
// store_lane_packer: narrows a GPR store to byte lanes of a word-addressed write port.
// Latency: 1 cycle request-to-beat; exception pulse 1 cycle after acceptance.
// Backpressure: beat held stable while mem_ready=0; req_ready low until the held beat drains.
// Ports: clk/reset; req_* (valid/ready request); mem_* (valid/ready write beat); exc_valid/exc_badvaddr.
// Optional feature macro: STORE_LANE_SPLIT_EN (misaligned half/word split into two beats).
module store_lane_packer
  import store_lane_packer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANES-1:0]  mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              exc_valid,
  output logic [ADDR_W-1:0] exc_badvaddr
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LANES-1:0]  be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              exc_valid_q, exc_valid_d;
  logic [ADDR_W-1:0] badv_q, badv_d;

  logic [LANES-1:0]  gen_be;
  logic [DATA_W-1:0] gen_wdata;
  logic              gen_misaligned;
  logic              accept;
  logic [ADDR_W-1:0] base_addr;

  assign base_addr = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef STORE_LANE_SPLIT_EN
  logic              pend_q, pend_d;  // second beat waiting behind the FULL one
  logic [ADDR_W-1:0] addr2_q, addr2_d;
  logic [LANES-1:0]  be2_q, be2_d;
  logic [DATA_W-1:0] wdata2_q, wdata2_d;
  logic [LANES-1:0]  gen_be2;
  logic [DATA_W-1:0] gen_wdata2;
  logic              gen_needs_second;
`endif

  store_lane_gen u_lane_gen (
    .off          (req_addr[1:0]),
    .size         (size_e'(req_size)),
    .data         (req_data),
    .be           (gen_be),
    .wdata        (gen_wdata),
`ifdef STORE_LANE_SPLIT_EN
    .be2          (gen_be2),
    .wdata2       (gen_wdata2),
    .needs_second (gen_needs_second),
`endif
    .misaligned   (gen_misaligned)
  );

`ifdef STORE_LANE_SPLIT_EN
  // A pending second beat must go out before anything new is accepted.
  assign req_ready = (state_q == ST_IDLE) || (state_q == ST_FULL && mem_ready && !pend_q);
`else
  assign req_ready = (state_q == ST_IDLE) || (state_q == ST_FULL && mem_ready);
`endif
  assign accept = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    badv_d      = badv_q;
    exc_valid_d = 1'b0;
`ifdef STORE_LANE_SPLIT_EN
    pend_d      = pend_q;
    addr2_d     = addr2_q;
    be2_d       = be2_q;
    wdata2_d    = wdata2_q;
`endif

    if (state_q != ST_IDLE && mem_ready) begin
      state_d = ST_IDLE;
    end
`ifdef STORE_LANE_SPLIT_EN
    if (state_q == ST_FULL && mem_ready && pend_q) begin
      state_d = ST_SECOND;
      addr_d  = addr2_q;
      be_d    = be2_q;
      wdata_d = wdata2_q;
      pend_d  = 1'b0;
    end
`endif

    // An exception request never enters the output stage, so a beat
    // draining in the same cycle is unaffected.
    if (accept) begin
      if (gen_misaligned) begin
        exc_valid_d = 1'b1;
        badv_d      = req_addr;
      end else begin
        state_d = ST_FULL;
        addr_d  = base_addr;
        be_d    = gen_be;
        wdata_d = gen_wdata;
`ifdef STORE_LANE_SPLIT_EN
        pend_d   = gen_needs_second;
        addr2_d  = base_addr + ADDR_W'(4);  // wraps to 0 past the top word
        be2_d    = gen_be2;
        wdata2_d = gen_wdata2;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      exc_valid_q <= 1'b0;
      badv_q      <= '0;
`ifdef STORE_LANE_SPLIT_EN
      pend_q      <= 1'b0;
      addr2_q     <= '0;
      be2_q       <= '0;
      wdata2_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      exc_valid_q <= exc_valid_d;
      badv_q      <= badv_d;
`ifdef STORE_LANE_SPLIT_EN
      pend_q      <= pend_d;
      addr2_q     <= addr2_d;
      be2_q       <= be2_d;
      wdata2_q    <= wdata2_d;
`endif
    end
  end

  assign mem_valid    = (state_q != ST_IDLE);
  assign mem_addr     = addr_q;
  assign mem_be       = be_q;
  assign mem_wdata    = wdata_q;
  assign exc_valid    = exc_valid_q;
  assign exc_badvaddr = badv_q;

endmodule

// File: doc/store_lane_packer.md
Name: store_lane_packer

Overview:
- Store-side counterpart of the immediate/load extenders in the P6 pipelined MIPS core.
- Narrows a 32-bit GPR value to word, half or byte and places it on the correct byte lanes of a word-addressed data-memory write port.
- Generates per-lane byte enables and flags misaligned addresses.
- Sits between the MEM-stage store request and the data-memory bus, with a registered output stage and a valid/ready handshake on both sides.

Parameters:
- ADDR_W, 32, width of byte address and memory address.
- DATA_W, 32, datapath width; fixed at 32, and the lane logic assumes 4 byte lanes.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_addr  in  32  byte address
- req_data  in  32  GPR rt value, with the value in the low bits
- req_size  in  2  0=word, 1=half, 2=byte, 3=reserved
- mem_valid  out  1  write beat present
- mem_ready  in  1  memory accepts beat
- mem_addr  out  32  word-aligned address, with [1:0] always 0
- mem_be  out  4  byte enables; bit i enables byte lane i (little-endian)
- mem_wdata  out  32  lane-placed write data
- exc_valid  out  1  one-cycle pulse: address-error-on-store
- exc_badvaddr  out  32  offending byte address, valid while exc_valid=1

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: mem_valid=0, mem_be=0, mem_wdata=0, mem_addr=0, exc_valid=0, exc_badvaddr=0. The FSM goes to IDLE.
- Reset mid-operation: any pending beat is discarded without being issued.
- FSM states: IDLE (output empty), FULL (one beat held), SECOND (second beat of a split store pending; SPLIT build only).
- req_ready = (state==IDLE) || (state==FULL && mem_ready). In SECOND, req_ready=0.
- Latency: an accepted aligned request produces mem_valid=1 on the next cycle.
- Hold rule: mem_* outputs stay stable while mem_valid && !mem_ready. A beat completes on mem_valid && mem_ready.
- Back-to-back: in FULL, if mem_ready and a new request arrive in the same cycle, the state stays FULL and the new beat loads. There are no bubbles.
- Lane rule, byte: mem_be = 1 << addr[1:0]; mem_wdata = {4{data[7:0]}}.
- Lane rule, half: mem_be = addr[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{data[15:0]}}.
- Lane rule, word: mem_be = 4'b1111; mem_wdata = data.
- mem_addr = {addr[31:2], 2'b00} in all cases.
- Misaligned, base build: half with addr[0]=1, word with addr[1:0]!=0, or req_size=3.
  - Accepted normally, but no memory beat is issued.
  - Next cycle: exc_valid=1 for exactly one cycle, exc_badvaddr=req_addr.
  - The state returns to, or stays in, IDLE.
  - exc_valid does not wait for mem_ready.
- Simultaneous events: if an exception request is accepted while a FULL beat completes, the beat completes and the exception pulse occurs. There is no ordering hazard.

Optional Feature:
- Macro: STORE_LANE_SPLIT_EN.
- Defined: misaligned halves and words are legal. req_size=3 still raises exc_valid.
  - Let k = addr[1:0].
  - First beat: be = (4'b1111 or 4'b0011) << k, truncated to 4 bits; wdata = data << 8k; at the base word.
  - If bytes overflow the word, the FSM enters SECOND and issues a second beat at base+4 with the remaining enables in the low lanes and wdata = data >> 8(4-k).
  - Half at k=1 or k=2 needs no split.
  - Address wrap at 0xFFFFFFFC+4 rolls over to 0.
  - The second beat follows the first with no idle cycle if mem_ready is high.
- Undefined: the misaligned exception path as above; no SECOND state is synthesised.

Decomposition:
- Shared package holds:
  - size encodings SZ_WORD, SZ_HALF, SZ_BYTE, SZ_RSVD, consistent with the extender op encodings;
  - the FSM state enum;
  - the lane count constant.
- One natural combinational sub-module, store_lane_gen: maps (addr[1:0], size, data) to (be, wdata, misaligned, needs_second).

Test Plan:
- SB, addr=0x1003, data=0xAABBCC5A, mem_ready=1:
  - next cycle mem_valid=1, mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0x5A5A5A5A.
- SH, addr=0x2002, data=0x1234BEEF, with mem_ready held low 3 cycles:
  - mem_be=4'b1100 and mem_wdata=0xBEEFBEEF stable throughout;
  - req_ready=0 until mem_ready=1.
- Three SW back-to-back at 0x0, 0x4, 0x8 with mem_ready=1:
  - three consecutive mem_valid beats, be=1111, no gaps.
- SW, addr=0x3001 (base build):
  - no mem_valid; exc_valid pulse of 1 cycle with exc_badvaddr=0x3001;
  - req_size=3 gives the same result.
- STORE_LANE_SPLIT_EN, SW addr=0x4003, data=0x11223344:
  - beat 1: addr 0x4000, be=1000, wdata=0x44000000;
  - beat 2: addr 0x4004, be=0111, wdata=0x00112233.
- Reset asserted while in FULL with mem_ready=0:
  - the next cycle mem_valid=0 and req_ready=1.
